// File: rtl/ext_io_bank_if.sv
// Memory-mapped bus between the processor data-memory port and the external I/O bank.
// Single-cycle strobes with a registered read return and a one-cycle valid pulse.
interface ext_io_bank_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_we;
  logic              bus_re;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_rvalid;

  modport master (
    output bus_addr, bus_wdata, bus_we, bus_re,
    input  bus_rdata, bus_rvalid
  );

  modport slave (
    input  bus_addr, bus_wdata, bus_we, bus_re,
    output bus_rdata, bus_rvalid
  );
endinterface

// File: rtl/ext_io_bank.sv
// External-world I/O bank: synchronised inputs, output registers, sticky change flags
// with write-one-to-clear, and a maskable level interrupt on a memory-mapped bus.
module ext_io_bank #(
  parameter int unsigned          DATA_W      = 8,
  parameter int unsigned          NUM_CH      = 4,
  parameter int unsigned          ADDR_W      = 8,
  parameter logic [ADDR_W-1:0]    BASE_ADDR   = 8'hF0,
  parameter int unsigned          SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     Reset,
  ext_io_bank_if.slave             bus,
  input  logic [NUM_CH*DATA_W-1:0] InpExtWorld,
  output logic [NUM_CH*DATA_W-1:0] OutExtWorld,
  output logic                     irq
);

  localparam int unsigned BUS_W    = NUM_CH * DATA_W;
  localparam int unsigned OFF_W    = ADDR_W + 1;
  localparam int unsigned OFF_OUT  = NUM_CH;
  localparam int unsigned OFF_STAT = 2 * NUM_CH;
  localparam int unsigned OFF_MASK = 2 * NUM_CH + 1;
  localparam int unsigned PRIME_N  = SYNC_STAGES + 1;
  localparam int unsigned PRIME_W  = $clog2(PRIME_N + 1);

  logic [BUS_W-1:0]   r_sync [SYNC_STAGES];
  logic [BUS_W-1:0]   r_in_prev;
  logic [BUS_W-1:0]   r_out;
  logic [NUM_CH-1:0]  r_status;
  logic [NUM_CH-1:0]  r_mask;
  logic [PRIME_W-1:0] r_prime;
  logic [DATA_W-1:0]  r_rdata;
  logic               r_rvalid;
  logic               r_irq;

  logic [OFF_W-1:0]   w_off;
  logic               w_hit;
  logic [BUS_W-1:0]   w_in;
  logic               w_primed;
  logic [NUM_CH-1:0]  w_chg;
  logic [NUM_CH-1:0]  w_wr_out;
  logic               w_wr_stat;
  logic               w_wr_mask;
  logic [NUM_CH-1:0]  w_clr;
  logic [DATA_W-1:0]  w_rdata;

  // Borrow into the extra MSB marks addresses below the base, so no wrap-around hits.
  assign w_off    = {1'b0, bus.bus_addr} - {1'b0, BASE_ADDR};
  assign w_hit    = !w_off[ADDR_W] && (w_off <= OFF_W'(OFF_MASK));
  assign w_in     = r_sync[SYNC_STAGES-1];
  assign w_primed = (r_prime == PRIME_W'(PRIME_N));

  // Per-channel change detect on the synchronised value, gated until the chain is primed.
  always_comb begin
    w_chg = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      w_chg[k] = w_primed && (w_in[k*DATA_W +: DATA_W] != r_in_prev[k*DATA_W +: DATA_W]);
    end
  end

  // Address decode: read mux and write enables.
  always_comb begin
    w_rdata   = '0;
    w_wr_out  = '0;
    w_wr_stat = 1'b0;
    w_wr_mask = 1'b0;
    if (w_hit) begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        if (w_off == OFF_W'(k)) begin
          w_rdata = w_in[k*DATA_W +: DATA_W];
        end
        if (w_off == OFF_W'(OFF_OUT + k)) begin
          w_rdata     = r_out[k*DATA_W +: DATA_W];
          w_wr_out[k] = bus.bus_we;
        end
      end
      if (w_off == OFF_W'(OFF_STAT)) begin
        w_rdata   = DATA_W'(r_status);
        w_wr_stat = bus.bus_we;
      end
      if (w_off == OFF_W'(OFF_MASK)) begin
        w_rdata   = DATA_W'(r_mask);
        w_wr_mask = bus.bus_we;
      end
    end
  end

  assign w_clr = w_wr_stat ? bus.bus_wdata[NUM_CH-1:0] : '0;

  // Input synchroniser chain plus one-cycle history for change detection.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
      r_in_prev <= '0;
      r_prime   <= '0;
    end else begin
      r_sync[0] <= InpExtWorld;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_in_prev <= w_in;
      if (!w_primed) begin
        r_prime <= r_prime + PRIME_W'(1);
      end
    end
  end

  // Register file, read return and interrupt; a new change beats a same-edge W1C.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_out    <= '0;
      r_status <= '0;
      r_mask   <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        if (w_wr_out[k]) begin
          r_out[k*DATA_W +: DATA_W] <= bus.bus_wdata;
        end
      end
      r_status <= (r_status & ~w_clr) | w_chg;
      if (w_wr_mask) begin
        r_mask <= bus.bus_wdata[NUM_CH-1:0];
      end
      r_rvalid <= bus.bus_re && w_hit;
      if (bus.bus_re && w_hit) begin
        r_rdata <= w_rdata;
      end
      r_irq <= |(r_status & r_mask);
    end
  end

  assign bus.bus_rdata  = r_rdata;
  assign bus.bus_rvalid = r_rvalid;
  assign OutExtWorld    = r_out;
  assign irq            = r_irq;

endmodule
